fft_out_serializer: RTL and testbench

FFT_OUT_SERIALIZER -- requirements
Module: fft_out_serializer

---
 rtl/fft_out_serializer.sv | 65 ++++++
 tb/tb_fft_out_serializer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fft_out_serializer.sv
// fft_out_serializer: captures a 32-sample FFT frame in parallel and streams it out with valid/ready.
// Define FFT_BITREV_EN to emit bit-reversed capture order as natural bin order.
module fft_out_serializer #(
    parameter int NUMBER_BITS = 22
) (
    input  logic                        clk_10,
    input  logic                        rst_n,
    input  logic                        load,
    input  logic [64*NUMBER_BITS-1:0]   data_in,
    output logic [2*NUMBER_BITS-1:0]    out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [4:0]                  out_index,
    output logic                        out_last,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        overrun
);
    localparam int W = 2 * NUMBER_BITS;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t       state;
    logic [4:0]   cnt;
    logic [4:0]   addr;
    logic [W-1:0] mem [32];
    logic         xfer;
    logic         capture;

`ifdef FFT_BITREV_EN
    assign addr = {cnt[0], cnt[1], cnt[2], cnt[3], cnt[4]};
`else
    assign addr = cnt;
`endif

    assign out_valid = (state == STREAM);
    assign busy      = out_valid;
    assign out_index = addr;
    assign out_data  = mem[addr];
    assign out_last  = out_valid && (cnt == 5'd31);
    assign xfer      = out_valid && out_ready;
    // a load riding on the final transfer starts the next frame without a bubble
    assign capture   = load && (!out_valid || (xfer && cnt == 5'd31));

    always_ff @(posedge clk_10 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else begin
            frame_done <= xfer && (cnt == 5'd31);
            if (capture) begin
                for (int i = 0; i < 32; i++) mem[i] <= data_in[i*W +: W];
                cnt   <= '0;
                state <= STREAM;
            end else if (xfer) begin
                cnt <= cnt + 5'd1;
                if (cnt == 5'd31) state <= IDLE;
            end
            if (load && !capture) overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fft_out_serializer.sv
// tb_fft_out_serializer: randomized scoreboard bench for fft_out_serializer.
// The model tracks remaining transfers and queues the expected sample sequence per accepted frame.
module tb_fft_out_serializer;
    localparam int NB = 22;
    localparam int W  = 2 * NB;
    localparam int FW = 32 * W;

    typedef struct {
        logic [W-1:0] d;
        int           idx;
        logic         last;
    } exp_t;

    logic          clk_10, rst_n, load, out_ready;
    logic [FW-1:0] data_in;
    logic [W-1:0]  out_data;
    logic          out_valid, out_last, busy, frame_done, overrun;
    logic [4:0]    out_index;

    int   checks = 0;
    int   errors = 0;
    int   rem = 0;
    logic exp_fd = 0;
    logic exp_ov = 0;
    exp_t q[$];

    fft_out_serializer #(.NUMBER_BITS(NB)) dut (
        .clk_10(clk_10), .rst_n(rst_n), .load(load), .data_in(data_in),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_index(out_index), .out_last(out_last), .busy(busy),
        .frame_done(frame_done), .overrun(overrun)
    );

    initial clk_10 = 1'b0;
    always #5 clk_10 = ~clk_10;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", n, a, e, $time);
        end
    endtask

    // bin emitted at position j of a frame
    function automatic int maddr(input int j);
        int r;
        r = j;
`ifdef FFT_BITREV_EN
        r = 0;
        for (int b = 0; b < 5; b++) if ((j >> b) % 2 == 1) r += 16 >> b;
`endif
        return r;
    endfunction

    function automatic logic [FW-1:0] rand_frame();
        logic [FW-1:0] f;
        for (int i = 0; i < FW / 32 + 1; i++)
            for (int b = 0; b < 32; b++) if (i*32 + b < FW) f[i*32 + b] = 1'($urandom);
        return f;
    endfunction

    task automatic push_frame(input logic [FW-1:0] f);
        exp_t e;
        for (int j = 0; j < 32; j++) begin
            e.idx  = maddr(j);
            e.d    = f[e.idx*W +: W];
            e.last = (j == 31);
            q.push_back(e);
        end
    endtask

    // drive one clock cycle and advance the reference model across its rising edge
    task automatic step(input logic ld, input logic rdy, input logic [FW-1:0] f);
        logic xfer, acc;
        int   old;
        load      = ld;
        out_ready = rdy;
        data_in   = f;
        old  = rem;
        xfer = (rem > 0) && rdy;
        acc  = ld && (rem == 0 || (rem == 1 && xfer));
        @(posedge clk_10);
        #1;
        if (xfer) rem--;
        if (acc) begin
            push_frame(f);
            rem = 32;
        end else if (ld) exp_ov = 1'b1;
        exp_fd = xfer && (old == 1);
        load   = 1'b0;
    endtask

    task automatic drain(input int mode, output int cyc);
        cyc = 0;
        while (rem > 0 && cyc < 400) begin
            step(1'b0, mode == 0 ? 1'b1 : (mode == 1 ? 1'(cyc % 3 == 0) : 1'($urandom)), '0);
            cyc++;
        end
        if (rem > 0) chk("drain_timeout", 64'(rem), 64'd0);
    endtask

    task automatic chk_zero(input string n);
        chk({n, "_valid"}, 64'(out_valid), 0);
        chk({n, "_busy"}, 64'(busy), 0);
        chk({n, "_last"}, 64'(out_last), 0);
        chk({n, "_done"}, 64'(frame_done), 0);
        chk({n, "_overrun"}, 64'(overrun), 0);
        chk({n, "_index"}, 64'(out_index), 0);
        chk({n, "_data"}, 64'(out_data), 0);
    endtask

    always @(negedge clk_10) begin
        chk("valid", 64'(out_valid), 64'(rem > 0));
        chk("busy", 64'(busy), 64'(rem > 0));
        chk("frame_done", 64'(frame_done), 64'(exp_fd));
        chk("overrun", 64'(overrun), 64'(exp_ov));
        if (rem > 0) begin
            if (q.size() == 0) chk("queue_empty", 64'd0, 64'd1);
            else begin
                chk("data", 64'(out_data), 64'(q[0].d));
                chk("index", 64'(out_index), 64'(q[0].idx));
                chk("last", 64'(out_last), 64'(q[0].last));
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        logic [FW-1:0] f;
        int cyc;
        rst_n = 1'b0;
        load = 1'b0;
        out_ready = 1'b0;
        data_in = '0;
        #1;
        chk_zero("reset");
        repeat (2) @(posedge clk_10);
        #1;
        rst_n = 1'b1;
        step(1'b0, 1'b1, '0);

        for (int k = 0; k < 32; k++) f[k*W +: W] = {NB'(k + 1), NB'(0)};
        step(1'b1, 1'b1, f);
        drain(0, cyc);
        chk("basic_cycles", 64'(cyc), 64'd32);
        step(1'b0, 1'b1, '0);

        step(1'b1, 1'b1, rand_frame());
        drain(1, cyc);
        step(1'b0, 1'b0, '0);

        step(1'b1, 1'b1, rand_frame());
        cyc = 0;
        while (rem > 1 && cyc < 100) begin
            step(1'b0, 1'b1, '0);
            cyc++;
        end
        step(1'b1, 1'b1, rand_frame());
        drain(0, cyc);
        chk("b2b_tail_cycles", 64'(cyc), 64'd32);
        step(1'b0, 1'b1, '0);

        step(1'b1, 1'b1, rand_frame());
        repeat (5) step(1'b0, 1'b1, '0);
        step(1'b1, 1'b1, rand_frame());
        chk("overrun_set", 64'(overrun), 64'd1);
        drain(0, cyc);
        step(1'b0, 1'b1, '0);
        chk("overrun_sticky", 64'(overrun), 64'd1);

        step(1'b1, 1'b1, rand_frame());
        repeat (10) step(1'b0, 1'b1, '0);
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        q.delete();
        rem = 0;
        exp_fd = 1'b0;
        exp_ov = 1'b0;
        step(1'b0, 1'b1, '0);
        rst_n = 1'b1;
        repeat (4) step(1'b0, 1'b1, '0);

        for (int k = 0; k < 32; k++) f[k*W +: W] = W'(k);
        step(1'b1, 1'b1, f);
        drain(0, cyc);
        step(1'b0, 1'b1, '0);

        for (int i = 0; i < 600; i++) step(1'($urandom_range(0, 7) == 0), 1'($urandom), rand_frame());
        drain(2, cyc);
        step(1'b0, 1'b1, '0);
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
